// File: rtl/stage_4_butterfly.sv
// -----------------------------------------------------------------------------
// stage_4_butterfly
//   Radix-2 Cooley-Tukey butterfly stage of the 1024-point, 32-lane NTT pipeline.
//   Each beat carries INPUT_PER_CYCLE lanes; butterfly k combines lanes 2k and
//   2k+1 with twiddle slice k read from an external synchronous ROM:
//     out[2k]   = (a + w*b) mod Q
//     out[2k+1] = (a - w*b) mod Q
//   Fixed latency of 4 cycles, no backpressure.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active low
//   in_valid   input beat present
//   in_sop     input beat is beat 0 of a new frame (qualified by in_valid)
//   inData     packed input lanes, lane i at [i*W +: W]
//   tw_rd_en   twiddle ROM read strobe (combinational, = in_valid)
//   tw_addr    twiddle ROM row = beat index (combinational)
//   tw_data    twiddle row, slice k at [k*W +: W], valid one cycle after read
//   out_valid  outData valid
//   out_last   outData is the final beat of a frame
//   outData    packed result lanes
// -----------------------------------------------------------------------------
module stage_4_butterfly #(
    parameter int unsigned DATA_WIDTH_PER_INPUT = 32,
    parameter int unsigned INPUT_PER_CYCLE      = 32,
    parameter int unsigned MODULUS              = 12289,
    parameter int unsigned BEATS_PER_FRAME      = 32
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                in_valid,
    input  logic                                                in_sop,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0]     inData,
    output logic                                                tw_rd_en,
    output logic [$clog2(BEATS_PER_FRAME)-1:0]                  tw_addr,
    input  logic [(INPUT_PER_CYCLE/2)*DATA_WIDTH_PER_INPUT-1:0] tw_data,
    output logic                                                out_valid,
    output logic                                                out_last,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0]     outData
);

    localparam int unsigned W  = DATA_WIDTH_PER_INPUT;
    localparam int unsigned N  = INPUT_PER_CYCLE;
    localparam int unsigned H  = INPUT_PER_CYCLE / 2;
    localparam int unsigned CW = $clog2(BEATS_PER_FRAME);

    localparam logic [W:0]     Q_EXT    = (W + 1)'(MODULUS);
    localparam logic [2*W-1:0] Q_WIDE   = (2 * W)'(MODULUS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(BEATS_PER_FRAME - 1);

    // Beat index / ROM addressing
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_idx;

    assign w_idx    = in_sop ? '0 : r_beat_cnt;
    assign tw_rd_en = in_valid;
    assign tw_addr  = w_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= '0;
        end else if (in_valid) begin
            r_beat_cnt <= (w_idx == LAST_IDX) ? '0 : w_idx + 1'b1;
        end
    end

    // S1: capture beat; the ROM row for this beat lands on tw_data in this stage
    logic           r_s1_valid;
    logic [N*W-1:0] r_s1_data;
    logic [CW-1:0]  r_s1_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= inData;
                r_s1_idx  <= w_idx;
            end
        end
    end

    // S2: full-width products w*b
    logic           r_s2_valid;
    logic           r_s2_last;
    logic [2*W-1:0] r_s2_prod [H];
    logic [W-1:0]   r_s2_a    [H];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            for (int k = 0; k < H; k++) begin
                r_s2_prod[k] <= '0;
                r_s2_a[k]    <= '0;
            end
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_last <= (r_s1_idx == LAST_IDX);
                for (int k = 0; k < H; k++) begin
                    r_s2_prod[k] <= (2 * W)'(tw_data[k*W +: W])
                                  * (2 * W)'(r_s1_data[(2*k+1)*W +: W]);
                    r_s2_a[k]    <= r_s1_data[(2*k)*W +: W];
                end
            end
        end
    end

    // S3: exact reduction by the constant modulus
    logic         r_s3_valid;
    logic         r_s3_last;
    logic [W-1:0] r_s3_wb [H];
    logic [W-1:0] r_s3_a  [H];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s3_valid <= 1'b0;
            r_s3_last  <= 1'b0;
            for (int k = 0; k < H; k++) begin
                r_s3_wb[k] <= '0;
                r_s3_a[k]  <= '0;
            end
        end else begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3_last <= r_s2_last;
                for (int k = 0; k < H; k++) begin
                    r_s3_wb[k] <= W'(r_s2_prod[k] % Q_WIDE);
                    r_s3_a[k]  <= r_s2_a[k];
                end
            end
        end
    end

    // S4: modular add/sub, one conditional correction each. Subtraction is
    // biased by +Q so the raw value is never negative.
    logic [W:0]     w_sum_raw [H];
    logic [W:0]     w_dif_raw [H];
    logic [N*W-1:0] w_bf;

    always_comb begin
        w_bf = '0;
        for (int k = 0; k < H; k++) begin
            w_sum_raw[k] = {1'b0, r_s3_a[k]} + {1'b0, r_s3_wb[k]};
            w_dif_raw[k] = {1'b0, r_s3_a[k]} + Q_EXT - {1'b0, r_s3_wb[k]};
            w_bf[(2*k)*W +: W]   = (w_sum_raw[k] >= Q_EXT) ? W'(w_sum_raw[k] - Q_EXT)
                                                           : W'(w_sum_raw[k]);
            w_bf[(2*k+1)*W +: W] = (w_dif_raw[k] >= Q_EXT) ? W'(w_dif_raw[k] - Q_EXT)
                                                           : W'(w_dif_raw[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            outData   <= '0;
        end else begin
            out_valid <= r_s3_valid;
            out_last  <= r_s3_valid & r_s3_last;
            if (r_s3_valid) begin
                outData <= w_bf;
            end
        end
    end

endmodule

// File: tb/tb_stage_4_butterfly.sv
// -----------------------------------------------------------------------------
// tb_stage_4_butterfly
//   Directed bench for stage_4_butterfly with a behavioural model: every driven
//   beat is turned into its expected output beat by plain modular arithmetic
//   and queued with its due cycle; one compare process checks the DUT every
//   cycle. Literal expectations pin the model on the basic vectors.
// -----------------------------------------------------------------------------
module tb_stage_4_butterfly;

    localparam int W   = 32;
    localparam int N   = 32;
    localparam int H   = 16;
    localparam int BPF = 32;
    localparam int CW  = 5;
    localparam longint unsigned Q = 12289;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_sop;
    logic [N*W-1:0] inData;
    logic           tw_rd_en;
    logic [CW-1:0]  tw_addr;
    logic [H*W-1:0] tw_data;
    logic           out_valid;
    logic           out_last;
    logic [N*W-1:0] outData;

    always #5 clk = ~clk;

    stage_4_butterfly #(
        .DATA_WIDTH_PER_INPUT(W),
        .INPUT_PER_CYCLE     (N),
        .MODULUS             (12289),
        .BEATS_PER_FRAME     (BPF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_sop   (in_sop),
        .inData   (inData),
        .tw_rd_en (tw_rd_en),
        .tw_addr  (tw_addr),
        .tw_data  (tw_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .outData  (outData)
    );

    // Synchronous twiddle ROM
    logic [W-1:0] rom [BPF][H];

    always @(posedge clk) begin
        if (tw_rd_en) begin
            for (int k = 0; k < H; k++) tw_data[k*W +: W] <= rom[tw_addr][k];
        end
    end

    // Model state
    typedef struct {
        int             due;
        logic [N*W-1:0] data;
        bit             last;
    } exp_t;

    exp_t           q[$];
    int             cyc = 0;
    int             m_cnt = 0;
    logic [N*W-1:0] last_data = '0;
    int             n_last = 0;
    int             n_checks = 0;
    int             n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N*W-1:0] mk_uniform(input int a, input int b);
        logic [N*W-1:0] d;
        for (int k = 0; k < H; k++) begin
            d[(2*k)*W +: W]   = W'(a);
            d[(2*k+1)*W +: W] = W'(b);
        end
        return d;
    endfunction

    function automatic logic [N*W-1:0] mk_pat(input int seed);
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = W'((seed * 97 + i * 389 + 11) % 12289);
        return d;
    endfunction

    task automatic set_rom_all(input int w);
        for (int r = 0; r < BPF; r++)
            for (int k = 0; k < H; k++) rom[r][k] = W'(w);
    endtask

    task automatic set_rom_pattern();
        for (int r = 0; r < BPF; r++)
            for (int k = 0; k < H; k++) rom[r][k] = W'((r * 1031 + k * 211 + 3) % 12289);
    endtask

    // Drive one beat and queue its expected result 4 cycles later
    task automatic send_beat(input bit sop, input logic [N*W-1:0] d);
        int idx;
        exp_t e;
        longint unsigned a, b, w, p;
        @(negedge clk);
        in_valid = 1'b1;
        in_sop   = sop;
        inData   = d;
        idx = sop ? 0 : m_cnt;
        #1;
        chk("tw_rd_en", 64'(tw_rd_en), 64'd1);
        chk("tw_addr", 64'(tw_addr), 64'(idx));
        for (int k = 0; k < H; k++) begin
            a = 64'(d[(2*k)*W +: W]);
            b = 64'(d[(2*k+1)*W +: W]);
            w = 64'(rom[idx][k]);
            p = (w * b) % Q;
            e.data[(2*k)*W +: W]   = W'((a + p) % Q);
            e.data[(2*k+1)*W +: W] = W'((a + Q - p) % Q);
        end
        e.last = (idx == BPF - 1);
        e.due  = cyc + 4;
        q.push_back(e);
        m_cnt = (idx + 1) % BPF;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        #1;
        chk("idle_rd_en", 64'(tw_rd_en), 64'd0);
        chk("idle_addr_hold", 64'(tw_addr), 64'(m_cnt));
    endtask

    // Wait for the single outstanding beat and pin it to literal values
    task automatic lit_check(input int ev, input int od);
        repeat (3) idle();
        @(negedge clk);
        #1;
        chk("lit_out_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < H; k++) begin
            chk("lit_even", 64'(outData[(2*k)*W +: W]), 64'(ev));
            chk("lit_odd", 64'(outData[(2*k+1)*W +: W]), 64'(od));
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        q.delete();
        last_data = '0;
        m_cnt     = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_outData_zero", 64'(|outData), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Compare process
    bit   cmp_ev;
    exp_t cmp_e;

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due < cyc) begin
            chk("missed_beat_due", 64'(cyc), 64'(q[0].due));
            void'(q.pop_front());
        end
        cmp_ev = (q.size() > 0) && (q[0].due == cyc);
        chk("out_valid", 64'(out_valid), 64'(cmp_ev));
        if (cmp_ev) begin
            cmp_e = q.pop_front();
            chk("out_last", 64'(out_last), 64'(cmp_e.last));
            for (int i = 0; i < N; i++)
                chk($sformatf("lane%0d", i), 64'(outData[i*W +: W]), 64'(cmp_e.data[i*W +: W]));
            last_data = cmp_e.data;
        end else begin
            chk("out_last_idle", 64'(out_last), 64'd0);
            chk("outData_hold", 64'(outData != last_data), 64'd0);
        end
        if (out_valid === 1'b1 && out_last === 1'b1) n_last++;
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        inData   = '0;
        tw_data  = '0;
        set_rom_all(1);
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_last", 64'(out_last), 64'd0);
        chk("reset_outData", 64'(|outData), 64'd0);
        chk("reset_tw_rd_en", 64'(tw_rd_en), 64'd0);
        chk("reset_tw_addr", 64'(tw_addr), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Basic butterfly vectors
        set_rom_all(1);
        send_beat(1'b1, mk_uniform(5, 3));
        lit_check(8, 2);
        send_beat(1'b1, mk_uniform(2, 5));
        lit_check(7, 12286);
        set_rom_all(2);
        send_beat(1'b1, mk_uniform(0, 12288));
        lit_check(12287, 2);

        // Full frame with a 3-cycle gap at beat 10, then a wrap to index 0
        set_rom_pattern();
        n_last = 0;
        send_beat(1'b1, mk_pat(0));
        for (int b = 1; b < 10; b++) send_beat(1'b0, mk_pat(b));
        repeat (3) idle();
        chk("gap_addr_is_10", 64'(tw_addr), 64'd10);
        for (int b = 10; b < BPF; b++) send_beat(1'b0, mk_pat(b));
        send_beat(1'b0, mk_pat(32));

        // Truncated frame: in_sop at beat 7, then a complete 32-beat frame
        for (int b = 1; b < 7; b++) send_beat(1'b0, mk_pat(40 + b));
        send_beat(1'b1, mk_pat(100));
        for (int b = 1; b < BPF; b++) send_beat(1'b0, mk_pat(100 + b));
        repeat (6) idle();
        chk("last_count", 64'(n_last), 64'd2);

        // Asynchronous reset with 3 beats in flight and one on the output
        for (int b = 0; b < 4; b++) send_beat(1'b0, mk_pat(200 + b));
        async_reset();
        repeat (6) idle();
        send_beat(1'b0, mk_pat(300));
        chk("post_reset_addr", 64'(tw_addr), 64'd0);

        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        chk("drain", 64'(q.size()), 64'd0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
